rr_arbiter_2to1: RTL

- Round-robin scheduler that shares the 2:1 8-bit mux datapath between two upstream first-word-fall-through FIFOs.
- Issues pop requests to the upstream FIFOs, serves each one in bursts of up to BURST_LEN words, and forwards the selected word as registered data_out/valid_out.
- Stalls on downstream almost-full backpressure.
- Sits between the lane FIFOs and the downstream FIFO/serializer.

---
 rtl/rr_arbiter_2to1_pkg.sv | 15 +
 rtl/rr_arbiter_2to1.sv | 119 +++++++++++
 2 files changed

// File: rtl/rr_arbiter_2to1_pkg.sv
// Shared constants for the two-port round-robin FIFO arbiter.
// The state codes double as the one-hot grant encoding.
package rr_arbiter_2to1_pkg;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_G0   = 2'b01;
    localparam logic [1:0] ST_G1   = 2'b10;

    localparam int DEFAULT_DATA_WIDTH = 8;

    function automatic logic [1:0] grant_state(input logic port);
        return port ? ST_G1 : ST_G0;
    endfunction

endpackage

// File: rtl/rr_arbiter_2to1.sv
// Round-robin burst scheduler popping two FWFT FIFOs into one registered output.
// Pops are combinational from the state register; data_out/valid_out lag a pop by one cycle.
module rr_arbiter_2to1
    import rr_arbiter_2to1_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in_0,
    input  logic                  empty_0,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic                  empty_1,
    input  logic                  almost_full_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            grant
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             last;
    logic             last_nxt;
    logic             own_sel;
    logic             own_empty;
    logic             other_empty;

    // Both grant states share one code path; own_sel names the port being served.
    assign own_sel     = (state == ST_G1);
    assign own_empty   = own_sel ? empty_1 : empty_0;
    assign other_empty = own_sel ? empty_0 : empty_1;
    assign cnt_inc     = cnt + 1'b1;

    assign pop_0 = (state == ST_G0) && !empty_0 && !almost_full_out;
    assign pop_1 = (state == ST_G1) && !empty_1 && !almost_full_out;
    assign grant = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (!empty_0 && !empty_1) begin
                    state_nxt = last ? ST_G0 : ST_G1;
                end else if (!empty_0) begin
                    state_nxt = ST_G0;
                end else if (!empty_1) begin
                    state_nxt = ST_G1;
                end
            end
            ST_G0, ST_G1: begin
                // Backpressure freezes the burst, so the count survives a stall.
                if (!almost_full_out) begin
                    if (own_empty) begin
                        cnt_nxt = '0;
                        if (!other_empty) begin
                            state_nxt = grant_state(!own_sel);
                        end else begin
                            state_nxt = ST_IDLE;
                            last_nxt  = own_sel;
                        end
                    end else begin
                        last_nxt = own_sel;
                        if (cnt_inc == CNT_LAST) begin
                            cnt_nxt = '0;
                            if (!other_empty) begin
                                state_nxt = grant_state(!own_sel);
                            end
                        end else begin
                            cnt_nxt = cnt_inc;
                        end
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_IDLE;
            cnt   <= '0;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            last  <= last_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= pop_0 | pop_1;
            if (pop_0) begin
                data_out <= data_in_0;
            end else if (pop_1) begin
                data_out <= data_in_1;
            end
        end
    end

endmodule
